// File: rtl/player_motion_if.sv
// Player motion bus: frame inputs from game logic, registered sprite state back.
interface player_motion_if #(
    parameter int W  = 10,
    parameter int FW = 4
);
    logic                centerPlayer;
    logic [31:0]         keycode;
    logic [W-1:0]        neededBallSize;
    logic [W-1:0]        step;
    logic [FW-1:0]       frictionFactor;
    logic [W-1:0]        BallX;
    logic [W-1:0]        BallY;
    logic signed [W-1:0] xVelocity;
    logic signed [W-1:0] yVelocity;
    logic [W-1:0]        BallS;
    logic                sprinting;
    logic                holding;

    modport master (
        output centerPlayer, keycode, neededBallSize, step, frictionFactor,
        input  BallX, BallY, xVelocity, yVelocity, BallS, sprinting, holding
    );

    modport slave (
        input  centerPlayer, keycode, neededBallSize, step, frictionFactor,
        output BallX, BallY, xVelocity, yVelocity, BallS, sprinting, holding
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// Per-player sprite motion controller, one update per video frame: accelerating
// velocity with speed cap and friction, clamping walls, sprint/cooldown and
// post-goal hold state machines, and sprite-size animation.
module player_motion_ctrl #(
    parameter int W             = 10,
    parameter int FW            = 4,
    parameter int X_CENTER      = 429,
    parameter int Y_CENTER      = 240,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 639,
    parameter int Y_MIN         = 0,
    parameter int Y_MAX         = 479,
    parameter int ACCEL         = 1,
    parameter int UP_BIT        = 4,
    parameter int LEFT_BIT      = 3,
    parameter int DOWN_BIT      = 2,
    parameter int RIGHT_BIT     = 1,
    parameter int SPRINT_BIT    = 0,
    parameter int SPRINT_FRAMES = 60,
    parameter int COOL_FRAMES   = 120,
    parameter int HOLD_FRAMES   = 3,
    parameter int DEFAULT_SIZE  = 8
) (
    input logic            frame_clk,
    input logic            Reset,
    player_motion_if.slave bus
);
    // Two guard bits keep position + velocity +/- size from wrapping.
    localparam int EW   = W + 2;
    localparam int VLIM = (1 << (W - 1)) - 1;
    localparam int SMAX = (SPRINT_FRAMES > COOL_FRAMES) ? SPRINT_FRAMES : COOL_FRAMES;
    localparam int SCW  = $clog2(SMAX + 1);
    localparam int HCW  = $clog2(HOLD_FRAMES + 1);

    localparam logic [SCW-1:0]       SPRINT_LOAD = SCW'(SPRINT_FRAMES - 1);
    localparam logic [SCW-1:0]       COOL_LOAD   = SCW'(COOL_FRAMES - 1);
    localparam logic [HCW-1:0]       HOLD_LOAD   = HCW'(HOLD_FRAMES - 1);
    localparam logic [EW-1:0]        VLIM_E      = EW'(VLIM);
    localparam logic signed [EW-1:0] ACC         = EW'(ACCEL);

    typedef enum logic       { PLAY, HOLD } main_t;
    typedef enum logic [1:0] { READY, SPRINT, COOL } sprint_t;

    main_t               main_q, main_d;
    sprint_t             spr_q, spr_d;
    logic [HCW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [SCW-1:0]      spr_cnt_q, spr_cnt_d;
    logic [W-1:0]        x_q, x_d, y_q, y_d, s_q, s_d;
    logic signed [W-1:0] vx_q, vx_d, vy_q, vy_d;
    logic signed [EW-1:0] vmax;
    logic                key_up, key_left, key_down, key_right, key_sprint, dir_any;
    logic                unused_keys;

    assign key_up      = bus.keycode[UP_BIT];
    assign key_left    = bus.keycode[LEFT_BIT];
    assign key_down    = bus.keycode[DOWN_BIT];
    assign key_right   = bus.keycode[RIGHT_BIT];
    assign key_sprint  = bus.keycode[SPRINT_BIT];
    assign dir_any     = (key_right != key_left) || (key_down != key_up);
    assign unused_keys = ^bus.keycode;

    // Speed limit; the boosted cap doubles the base and saturates at the signed maximum.
    function automatic logic signed [EW-1:0] speed_cap(input logic [W-1:0] base, input logic boost);
        logic [EW-1:0] raw;
        raw = boost ? {1'b0, base, 1'b0} : {2'b00, base};
        if (raw > VLIM_E) raw = VLIM_E;
        return $signed(raw);
    endfunction

    function automatic logic signed [EW-1:0] clamp_vel(input logic signed [EW-1:0] v,
                                                       input logic signed [EW-1:0] lim);
        if (v > lim)  return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    // Decay toward zero without crossing it.
    function automatic logic signed [EW-1:0] apply_friction(input logic signed [EW-1:0] v,
                                                            input logic [FW-1:0] f);
        logic signed [EW-1:0] fe;
        fe = $signed(EW'(f));
        if (v >= 0) return (v <= fe) ? '0 : v - fe;
        return (-v <= fe) ? '0 : v + fe;
    endfunction

    // One axis: move by the previous velocity, update velocity, then clamp at the walls.
    function automatic void axis_update(
        input  logic [W-1:0]         p,
        input  logic signed [W-1:0]  v,
        input  logic                 pos_key,
        input  logic                 neg_key,
        input  logic signed [EW-1:0] lim,
        input  logic [FW-1:0]        fric,
        input  logic [W-1:0]         size,
        input  int                   lo,
        input  int                   hi,
        output logic [W-1:0]         p_n,
        output logic signed [W-1:0]  v_n
    );
        logic signed [EW-1:0] pe, ve, se, vn;
        ve = EW'(v);
        se = $signed({2'b00, size});
        pe = $signed({2'b00, p}) + ve;
        if (pos_key != neg_key) vn = clamp_vel(ve + (pos_key ? ACC : -ACC), lim);
        else                    vn = apply_friction(ve, fric);
        if (pe - se < EW'(lo)) begin
            pe = EW'(lo) + se;
            vn = '0;
        end else if (pe + se > EW'(hi)) begin
            pe = EW'(hi) - se;
            vn = '0;
        end
        p_n = pe[W-1:0];
        v_n = vn[W-1:0];
    endfunction

    // Next state for hold and sprint FSMs plus the motion datapath.
    always_comb begin
        main_d     = main_q;
        hold_cnt_d = hold_cnt_q;
        spr_d      = spr_q;
        spr_cnt_d  = spr_cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        vmax       = speed_cap(bus.step, 1'b0);

        if (s_q < bus.neededBallSize)      s_d = s_q + 1'b1;
        else if (s_q > bus.neededBallSize) s_d = s_q - 1'b1;
        else                               s_d = s_q;

        if (bus.centerPlayer) begin
            main_d     = HOLD;
            hold_cnt_d = HOLD_LOAD;
            spr_d      = READY;
            spr_cnt_d  = '0;
            x_d        = W'(X_CENTER);
            y_d        = W'(Y_CENTER);
            vx_d       = '0;
            vy_d       = '0;
        end else if (main_q == HOLD) begin
            if (hold_cnt_q == '0) main_d = PLAY;
            else                  hold_cnt_d = hold_cnt_q - 1'b1;
        end else begin
            case (spr_q)
                READY: begin
                    if (key_sprint && dir_any) begin
                        spr_d     = SPRINT;
                        spr_cnt_d = SPRINT_LOAD;
                    end
                end
                SPRINT: begin
                    if (spr_cnt_q == '0 || !key_sprint) begin
                        spr_d     = COOL;
                        spr_cnt_d = COOL_LOAD;
                    end else begin
                        spr_cnt_d = spr_cnt_q - 1'b1;
                    end
                end
                COOL: begin
                    if (spr_cnt_q == '0) spr_d = READY;
                    else                 spr_cnt_d = spr_cnt_q - 1'b1;
                end
                default: begin
                    spr_d     = READY;
                    spr_cnt_d = '0;
                end
            endcase
            // Cap follows the sprint state being entered, so a sprint ending clamps at once.
            vmax = speed_cap(bus.step, spr_d == SPRINT);
            axis_update(x_q, vx_q, key_right, key_left, vmax, bus.frictionFactor, s_q,
                        X_MIN, X_MAX, x_d, vx_d);
            axis_update(y_q, vy_q, key_down, key_up, vmax, bus.frictionFactor, s_q,
                        Y_MIN, Y_MAX, y_d, vy_d);
        end
    end

    // Frame register for FSM state, counters and sprite state.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            main_q     <= PLAY;
            hold_cnt_q <= '0;
            spr_q      <= READY;
            spr_cnt_q  <= '0;
            x_q        <= W'(X_CENTER);
            y_q        <= W'(Y_CENTER);
            vx_q       <= '0;
            vy_q       <= '0;
            s_q        <= W'(DEFAULT_SIZE);
        end else begin
            main_q     <= main_d;
            hold_cnt_q <= hold_cnt_d;
            spr_q      <= spr_d;
            spr_cnt_q  <= spr_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            s_q        <= s_d;
        end
    end

    assign bus.BallX     = x_q;
    assign bus.BallY     = y_q;
    assign bus.xVelocity = vx_q;
    assign bus.yVelocity = vy_q;
    assign bus.BallS     = s_q;
    assign bus.sprinting = (spr_q == SPRINT);
    assign bus.holding   = (main_q == HOLD);
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: per-frame vector table plus
// hand-written wall, hold and sprint sequences.
module tb_player_motion_ctrl;
    localparam int W = 10;
    localparam logic [31:0] K_S = 32'h01;
    localparam logic [31:0] K_R = 32'h02;
    localparam logic [31:0] K_D = 32'h04;
    localparam logic [31:0] K_L = 32'h08;
    localparam logic [31:0] K_U = 32'h10;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    player_motion_if #(.W(W), .FW(4)) bus ();

    player_motion_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic [31:0] key;
        logic        ctr;
        int          step, fric, need;
        int          x, y, vx, vy, s;
        logic        spr, hold;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [31:0] key, input int step, fric, need,
                                input int x, y, vx, vy, s);
        vec_t v;
        v.key = key; v.ctr = 1'b0; v.step = step; v.fric = fric; v.need = need;
        v.x = x; v.y = y; v.vx = vx; v.vy = vy; v.s = s; v.spr = 1'b0; v.hold = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int x, y, vx, vy, s,
                             input logic spr, hold);
        check({tag, " BallX"}, bus.BallX, x);
        check({tag, " BallY"}, bus.BallY, y);
        check({tag, " xVelocity"}, bus.xVelocity, vx);
        check({tag, " yVelocity"}, bus.yVelocity, vy);
        check({tag, " BallS"}, bus.BallS, s);
        check({tag, " sprinting"}, bus.sprinting, spr);
        check({tag, " holding"}, bus.holding, hold);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] k, input logic c, input int st, fr, nd);
        bus.keycode        = k;
        bus.centerPlayer   = c;
        bus.step           = W'(st);
        bus.frictionFactor = 4'(fr);
        bus.neededBallSize = W'(nd);
    endtask

    task automatic frame_x(input string tag, input logic [31:0] k, input int ex, input int ev);
        bus.keycode = k;
        tick();
        check({tag, " BallX"}, bus.BallX, ex);
        check({tag, " xVelocity"}, bus.xVelocity, ev);
    endtask

    initial begin
        // key, step, fric, need -> BallX, BallY, xVel, yVel, BallS
        vecs.push_back(mk(K_R, 4, 1, 8,  429, 240, 1, 0, 8));
        vecs.push_back(mk(K_R, 4, 1, 8,  430, 240, 2, 0, 8));
        vecs.push_back(mk(K_R, 4, 1, 8,  432, 240, 3, 0, 8));
        vecs.push_back(mk(K_R, 4, 1, 8,  435, 240, 4, 0, 8));
        vecs.push_back(mk(K_R, 4, 1, 8,  439, 240, 4, 0, 8));
        vecs.push_back(mk(0,   4, 1, 8,  443, 240, 3, 0, 8));
        vecs.push_back(mk(0,   4, 1, 8,  446, 240, 2, 0, 8));
        vecs.push_back(mk(0,   4, 1, 8,  448, 240, 1, 0, 8));
        vecs.push_back(mk(0,   4, 1, 8,  449, 240, 0, 0, 8));
        vecs.push_back(mk(0,   4, 1, 8,  449, 240, 0, 0, 8));
        vecs.push_back(mk(K_R, 4, 1, 8,  449, 240, 1, 0, 8));
        vecs.push_back(mk(K_R, 4, 1, 8,  450, 240, 2, 0, 8));
        vecs.push_back(mk(K_R, 4, 1, 8,  452, 240, 3, 0, 8));
        vecs.push_back(mk(K_L | K_R, 4, 2, 8, 455, 240, 1, 0, 8));
        vecs.push_back(mk(K_L | K_R, 4, 2, 8, 456, 240, 0, 0, 8));
        vecs.push_back(mk(K_L | K_R, 4, 2, 8, 456, 240, 0, 0, 8));
        vecs.push_back(mk(K_U, 4, 1, 10, 456, 240, 0, -1, 9));
        vecs.push_back(mk(K_U, 4, 1, 10, 456, 239, 0, -2, 10));
        vecs.push_back(mk(K_D, 4, 1, 10, 456, 237, 0, -1, 10));
        vecs.push_back(mk(0,   4, 1, 10, 456, 236, 0, 0, 10));
        vecs.push_back(mk(0,   4, 1, 8,  456, 236, 0, 0, 9));
        vecs.push_back(mk(0,   4, 1, 8,  456, 236, 0, 0, 8));

        drive(0, 1'b0, 4, 1, 8);
        Reset = 1'b1;
        tick();
        tick();
        check_all("reset", 429, 240, 0, 0, 8, 1'b0, 1'b0);
        Reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].key, vecs[i].ctr, vecs[i].step, vecs[i].fric, vecs[i].need);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].vx, vecs[i].vy,
                      vecs[i].s, vecs[i].spr, vecs[i].hold);
        end

        // Ramp toward the right wall until BallX=630 with xVelocity=4.
        drive(K_R, 1'b0, 4, 1, 8);
        for (int k = 1; k <= 46; k++) begin
            int ex;
            int ev;
            tick();
            ev = (k < 4) ? k : 4;
            case (k)
                1:       ex = 456;
                2:       ex = 457;
                3:       ex = 459;
                default: ex = 462 + 4 * (k - 4);
            endcase
            check($sformatf("ramp%0d BallX", k), bus.BallX, ex);
            check($sformatf("ramp%0d xVelocity", k), bus.xVelocity, ev);
        end
        frame_x("wall_hit", K_R, 631, 0);
        frame_x("back_off", K_L, 631, -1);
        frame_x("coast", 0, 630, 0);
        frame_x("edge_start", K_R, 630, 1);
        frame_x("edge_equal", K_R, 631, 2);
        frame_x("edge_over", K_R, 631, 0);
        check("wall BallY", bus.BallY, 236);

        // Recentre while moving and sprinting, then reset inside HOLD.
        frame_x("pre_ctr1", K_L | K_S, 631, -1);
        check("pre_ctr1 sprinting", bus.sprinting, 1);
        frame_x("pre_ctr2", K_L | K_S, 630, -2);
        bus.centerPlayer = 1'b1;
        tick();
        check_all("ctr_pulse", 429, 240, 0, 0, 8, 1'b0, 1'b1);
        bus.centerPlayer = 1'b0;
        tick();
        check_all("hold2", 429, 240, 0, 0, 8, 1'b0, 1'b1);
        tick();
        check_all("hold3", 429, 240, 0, 0, 8, 1'b0, 1'b1);
        tick();
        check_all("hold_exit", 429, 240, 0, 0, 8, 1'b0, 1'b0);
        tick();
        check_all("hold_keys", 429, 240, -1, 0, 8, 1'b1, 1'b0);
        bus.centerPlayer = 1'b1;
        tick();
        check_all("ctr_again", 429, 240, 0, 0, 8, 1'b0, 1'b1);
        bus.centerPlayer = 1'b0;
        Reset = 1'b1;
        tick();
        check_all("reset_in_hold", 429, 240, 0, 0, 8, 1'b0, 1'b0);
        Reset = 1'b0;

        // Sprint weaving left/right to stay off the walls, then cooldown.
        drive(0, 1'b0, 4, 1, 8);
        for (int f = 1; f <= 70; f++) begin
            logic [31:0] k;
            int ev;
            if (f <= 12)      k = K_L | K_S;
            else if (f <= 28) k = K_R | K_S;
            else if (f <= 44) k = K_L | K_S;
            else if (f <= 61) k = K_R | K_S;
            else if (f <= 63) k = K_R;
            else              k = K_R | K_S;
            if (f <= 8)       ev = -f;
            else if (f <= 12) ev = -8;
            else if (f <= 28) ev = -8 + (f - 12);
            else if (f <= 44) ev = 8 - (f - 28);
            else if (f <= 60) ev = -8 + (f - 44);
            else              ev = 4;
            bus.keycode = k;
            tick();
            check($sformatf("sprint f%0d sprinting", f), bus.sprinting, (f <= 60) ? 1 : 0);
            check($sformatf("sprint f%0d xVelocity", f), bus.xVelocity, ev);
            if (f == 61) check("sprint f61 BallX", bus.BallX, 369);
            if (f == 62) check("sprint f62 BallX", bus.BallX, 373);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Parametrised next-generation player sprite controller for the soccer game; one instance per player, clocked once per video frame.
- Generalised over coordinate width, field bounds, key-bit mapping and acceleration.
- Adds over the previous player blocks: acceleration ramp with speed cap, clamping walls (no bounce), opposite-key cancel, sprint/cooldown FSM, and a post-goal hold FSM.
- Outputs feed the ball-collision and sprite-draw logic.

Parameters:
- W, 10, coordinate/velocity width; velocities are two's-complement W bits.
- FW, 4, friction input width.
- X_CENTER, 429, X position loaded on reset/center.
- Y_CENTER, 240, Y position loaded on reset/center.
- X_MIN, 0, leftmost field coordinate.
- X_MAX, 639, rightmost field coordinate.
- Y_MIN, 0, topmost field coordinate.
- Y_MAX, 479, bottommost field coordinate.
- ACCEL, 1, velocity increment per frame while a direction key is held.
- UP_BIT, 4, keycode bit for up.
- LEFT_BIT, 3, keycode bit for left.
- DOWN_BIT, 2, keycode bit for down.
- RIGHT_BIT, 1, keycode bit for right.
- SPRINT_BIT, 0, keycode bit for sprint.
- SPRINT_FRAMES, 60, maximum sprint duration in frames.
- COOL_FRAMES, 120, cooldown length in frames after a sprint.
- HOLD_FRAMES, 3, frames inputs are ignored after a center request.
- DEFAULT_SIZE, 8, size loaded at reset.

Ports:
- frame_clk  in  1  frame clock; sole clock.
- Reset  in  1  synchronous, active-high.
- centerPlayer  in  1  request to recentre (one-frame pulse or level).
- keycode  in  32  key bitmap.
- neededBallSize  in  W  target sprite radius.
- step  in  W  base speed cap (unsigned).
- frictionFactor  in  FW  velocity decay per frame (unsigned).
- BallX  out  W  X position.
- BallY  out  W  Y position.
- xVelocity  out  W  signed X velocity.
- yVelocity  out  W  signed Y velocity.
- BallS  out  W  current sprite radius.
- sprinting  out  1  high while sprint FSM is in SPRINT.
- holding  out  1  high while main FSM is in HOLD.

Behaviour:
- Reset (synchronous, highest priority):
  - BallX=X_CENTER, BallY=Y_CENTER, velocities=0, BallS=DEFAULT_SIZE.
  - Main FSM=PLAY, sprint FSM=READY, all counters=0.
  - sprinting=0, holding=0.
- All outputs are registered and change only on a frame_clk edge.
- Main FSM:
  - PLAY→HOLD when centerPlayer=1: load centre position, velocities=0, hold counter=HOLD_FRAMES-1, sprint FSM forced to READY.
  - In HOLD: keycode ignored; position and velocity frozen; counter decrements each frame.
  - HOLD→PLAY on the frame the counter=0 and centerPlayer=0.
  - centerPlayer=1 while in HOLD reloads the centre and reloads the counter.
- Axis direction per frame: dx=RIGHT-LEFT, dy=DOWN-UP, each in {-1,0,+1}. Opposite keys pressed together give 0.
- Speed cap: vmax=step in READY/COOL; vmax=step<<1 (saturating at 2^(W-1)-1) in SPRINT.
- Velocity per axis, PLAY only:
  - d≠0: v_next=clamp(v+d*ACCEL, -vmax, +vmax). If |v|>vmax (sprint just ended), v is clamped to ±vmax immediately.
  - d=0: v moves toward 0 by frictionFactor and never crosses 0 (|v|≤friction → 0).
- Position uses the previous registered velocity: p_next=p+v, computed in W+2-bit signed arithmetic (no wrap).
- Wall clamps on p_next:
  - p_next-BallS < MIN → p=MIN+BallS and v_next=0.
  - p_next+BallS > MAX → p=MAX-BallS and v_next=0.
  - Equality is legal.
  - Low check has priority over high if both fire.
  - Axes are evaluated independently in the same cycle.
- Sprint FSM (advances in PLAY only):
  - READY→SPRINT when the sprint key=1 and at least one direction is nonzero; counter=SPRINT_FRAMES-1.
  - SPRINT→COOL when the counter reaches 0 or the sprint key is released; counter=COOL_FRAMES-1.
  - COOL→READY when the counter reaches 0. The sprint key is ignored while in COOL.
- Size animation (always runs, including HOLD): BallS steps by 1 toward neededBallSize each frame.
- Simultaneous events: Reset > centerPlayer > wall clamp > key/friction update.

Test Plan:
- Reset asserted 2 frames → BallX=429, BallY=240, xVelocity=0, yVelocity=0, BallS=8, sprinting=0, holding=0.
- step=4, friction=1, RIGHT held from PLAY at (429,240) → xVelocity per frame 1,2,3,4,4; BallX per frame 429,430,432,435,439. Release RIGHT → xVelocity 3,2,1,0,0.
- BallX=630, xVelocity=4, BallS=8, RIGHT held → next frame BallX=631, xVelocity=0. With xVelocity=1, BallX=631 is reached with no clamp side-effect.
- LEFT+RIGHT held with xVelocity=3, friction=2 → xVelocity 1 then 0, never -1.
- step=4, RIGHT+SPRINT held 70 frames → xVelocity rises to 8; sprinting=1 for exactly 60 frames; xVelocity clamps to 4 on the first COOL frame. Re-press SPRINT within 120 frames → sprinting stays 0.
- centerPlayer pulsed 1 frame while moving with keys held → BallX=429, BallY=240, velocities=0; holding=1 for 3 frames; keys act on frame 4. Reset during HOLD → same values as the reset case.
